// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter BHT with mispredict flag; define BP_STATS_EN for branch/miss statistics counters
module branch_predictor #(
    parameter int         IDX_BITS   = 6,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pred_valid_i,
    input  logic [31:0] pred_pc_i,
    output logic        pred_taken_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic        upd_pred_i,
    output logic        mispredict_o,
`ifdef BP_STATS_EN
    output logic [31:0] bp_branch_cnt_o,
    output logic [31:0] bp_miss_cnt_o,
`endif
    output logic        busy_o
);
    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          bht [ENTRIES];
    logic [IDX_BITS-1:0] pred_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [1:0]          cur;
    logic [1:0]          nxt;
    logic                unused_pc_bits;

    assign pred_idx       = pred_pc_i[IDX_BITS+1:2];
    assign upd_idx        = upd_pc_i[IDX_BITS+1:2];
    assign pred_taken_o   = pred_valid_i & bht[pred_idx][1];
    assign mispredict_o   = upd_valid_i & (upd_taken_i ^ upd_pred_i);
    assign busy_o         = 1'b0;
    assign unused_pc_bits = ^{pred_pc_i[31:IDX_BITS+2], pred_pc_i[1:0], upd_pc_i[31:IDX_BITS+2], upd_pc_i[1:0]};

    // saturating increment/decrement of the counter being trained
    always_comb begin
        cur = bht[upd_idx];
        nxt = upd_taken_i ? ((cur == 2'b11) ? cur : cur + 2'd1)
                          : ((cur == 2'b00) ? cur : cur - 2'd1);
    end

    // table write; read-before-write so a same-cycle prediction sees the old value
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= INIT_STATE;
        end else if (upd_valid_i) begin
            bht[upd_idx] <= nxt;
        end
    end

`ifdef BP_STATS_EN
    // saturating counts of resolved branches and mispredictions
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bp_branch_cnt_o <= '0;
            bp_miss_cnt_o   <= '0;
        end else begin
            if (upd_valid_i && bp_branch_cnt_o != 32'hFFFF_FFFF) bp_branch_cnt_o <= bp_branch_cnt_o + 32'd1;
            if (mispredict_o && bp_miss_cnt_o != 32'hFFFF_FFFF) bp_miss_cnt_o <= bp_miss_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard-driven checks of prediction, training, aliasing, mispredict and reset
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_taken;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred = 1'b0;
    logic        mispredict;
    logic        busy;
`ifdef BP_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;
`endif

    typedef struct {
        string nm;
        logic  exp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .pred_valid_i (pred_valid),
        .pred_pc_i    (pred_pc),
        .pred_taken_o (pred_taken),
        .upd_valid_i  (upd_valid),
        .upd_pc_i     (upd_pc),
        .upd_taken_i  (upd_taken),
        .upd_pred_i   (upd_pred),
        .mispredict_o (mispredict),
`ifdef BP_STATS_EN
        .bp_branch_cnt_o (branch_cnt),
        .bp_miss_cnt_o   (miss_cnt),
`endif
        .busy_o       (busy)
    );

    task automatic do_upd(input logic [31:0] pc, input logic t, input logic p);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = t;
        upd_pred  = p;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        pred_valid = 1'b1;
        pred_pc    = 32'h40;
        sb.push_back('{nm: "reset_pred", exp: 1'b0});
        #3;
        e = sb.pop_front();
        tests++;
        if (pred_taken !== e.exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.nm, pred_taken, e.exp);
        end
        tests++;
        if (mispredict !== 1'b0) begin
            fails++;
            $display("FAIL reset_mispredict: got %b expected 0", mispredict);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_train();
        logic tk [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic ex [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        pred_valid = 1'b1;
        pred_pc    = 32'h40;
        for (int i = 0; i < 12; i++) begin
            sb.push_back('{nm: $sformatf("train_step%0d", i), exp: ex[i]});
            do_upd(32'h40, tk[i], 1'b0);
            e = sb.pop_front();
            tests++;
            if (pred_taken !== e.exp) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.nm, pred_taken, e.exp);
            end
        end
    endtask

    task automatic test_conflict();
        pred_valid = 1'b1;
        pred_pc    = 32'h80;
        upd_valid  = 1'b1;
        upd_pc     = 32'h80;
        upd_taken  = 1'b1;
        upd_pred   = 1'b0;
        sb.push_back('{nm: "conflict_same_cycle", exp: 1'b0});
        sb.push_back('{nm: "conflict_next_cycle", exp: 1'b1});
        #1;
        e = sb.pop_front();
        tests++;
        if (pred_taken !== e.exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.nm, pred_taken, e.exp);
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        #1;
        e = sb.pop_front();
        tests++;
        if (pred_taken !== e.exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.nm, pred_taken, e.exp);
        end
    endtask

    task automatic test_alias();
        logic [31:0] pcs [4] = '{32'h144, 32'h147, 32'h48, 32'h144};
        logic        vld [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        ex  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_upd(32'h44, 1'b1, 1'b0);
        do_upd(32'h44, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pred_valid = vld[i];
            pred_pc    = pcs[i];
            sb.push_back('{nm: $sformatf("alias_pc%0h_v%0b", pcs[i], vld[i]), exp: ex[i]});
            #1;
            e = sb.pop_front();
            tests++;
            if (pred_taken !== e.exp) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.nm, pred_taken, e.exp);
            end
        end
        pred_valid = 1'b1;
    endtask

    task automatic test_mispredict();
        logic uv [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic ut [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic up [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic ex [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        upd_pc = 32'h300;
        for (int i = 0; i < 6; i++) begin
            upd_valid = uv[i];
            upd_taken = ut[i];
            upd_pred  = up[i];
            sb.push_back('{nm: $sformatf("mispredict_v%0b_t%0b_p%0b", uv[i], ut[i], up[i]), exp: ex[i]});
            #1;
            e = sb.pop_front();
            tests++;
            if (mispredict !== e.exp) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.nm, mispredict, e.exp);
            end
        end
        upd_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [1:0]  m [64];
        logic [31:0] ppc;
        logic [31:0] upc;
        logic        pv;
        logic        uv;
        logic        ut;
        logic        up;
        logic        emis;
        do_reset();
        for (int i = 0; i < 64; i++) m[i] = 2'b01;
        for (int c = 0; c < 300; c++) begin
            ppc = $urandom_range(0, 1023);
            upc = $urandom_range(0, 1023);
            pv  = 1'($urandom_range(0, 3) != 0);
            uv  = 1'($urandom_range(0, 3) != 0);
            ut  = 1'($urandom_range(0, 1));
            up  = 1'($urandom_range(0, 1));
            pred_valid = pv;
            pred_pc    = ppc;
            upd_valid  = uv;
            upd_pc     = upc;
            upd_taken  = ut;
            upd_pred   = up;
            sb.push_back('{nm: $sformatf("rand_pred_c%0d", c), exp: pv & m[ppc[7:2]][1]});
            emis = uv & (ut ^ up);
            #1;
            e = sb.pop_front();
            tests++;
            if (pred_taken !== e.exp) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.nm, pred_taken, e.exp);
            end
            tests++;
            if (mispredict !== emis) begin
                fails++;
                $display("FAIL rand_mis_c%0d: got %b expected %b", c, mispredict, emis);
            end
            if (uv) begin
                if (ut && m[upc[7:2]] != 2'b11) m[upc[7:2]] = m[upc[7:2]] + 2'd1;
                if (!ut && m[upc[7:2]] != 2'b00) m[upc[7:2]] = m[upc[7:2]] - 2'd1;
            end
            @(posedge clk);
            #1;
        end
        upd_valid  = 1'b0;
        pred_valid = 1'b1;
    endtask

`ifdef BP_STATS_EN
    task automatic test_stats();
        logic t [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic p [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) do_upd(32'h200, t[i], p[i]);
        tests++;
        if (branch_cnt !== 32'd5) begin
            fails++;
            $display("FAIL stats_branch_cnt: got %0d expected 5", branch_cnt);
        end
        tests++;
        if (miss_cnt !== 32'd2) begin
            fails++;
            $display("FAIL stats_miss_cnt: got %0d expected 2", miss_cnt);
        end
    endtask
`endif

    task automatic test_async_reset();
        pred_valid = 1'b1;
        pred_pc    = 32'h40;
        for (int i = 0; i < 3; i++) do_upd(32'h40, 1'b1, 1'b1);
        sb.push_back('{nm: "areset_trained", exp: 1'b1});
        sb.push_back('{nm: "areset_immediate", exp: 1'b0});
        sb.push_back('{nm: "areset_update_aborted", exp: 1'b0});
        sb.push_back('{nm: "areset_after_release", exp: 1'b0});
        #1;
        e = sb.pop_front();
        tests++;
        if (pred_taken !== e.exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.nm, pred_taken, e.exp);
        end
        #1;
        rst_n     = 1'b0;
        upd_valid = 1'b1;
        upd_pc    = 32'h40;
        upd_taken = 1'b1;
        upd_pred  = 1'b1;
        #1;
        e = sb.pop_front();
        tests++;
        if (pred_taken !== e.exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.nm, pred_taken, e.exp);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL areset_busy: got %b expected 0", busy);
        end
`ifdef BP_STATS_EN
        tests++;
        if (branch_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            fails++;
            $display("FAIL areset_stats: got %0d/%0d expected 0/0", branch_cnt, miss_cnt);
        end
`endif
        @(posedge clk);
        #1;
        e = sb.pop_front();
        tests++;
        if (pred_taken !== e.exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.nm, pred_taken, e.exp);
        end
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        e = sb.pop_front();
        tests++;
        if (pred_taken !== e.exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.nm, pred_taken, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_train();
        test_conflict();
        test_alias();
        test_mispredict();
        test_random();
`ifdef BP_STATS_EN
        test_stats();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
